i2c_cmd_master: RTL and testbench

Bit-level I2C master that executes the 37-bit commands issued by the Si570/I2C-switch programming sequencers. It accepts one command per i2cstart pulse and raises i2cbusy for the whole transaction. It drives open-drain SCL/SDA enables toward the board I2C bus and returns ACK status and read data.

---
 rtl/i2c_cmd_master.sv | 183 ++++++++++++++++++
 tb/tb_i2c_cmd_master.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_cmd_master.sv
// Bit-level I2C master: runs one 37-bit command (address byte plus up to three
// write or read bytes) on open-drain SCL/SDA enables, with quarter-bit ticks.
module i2c_cmd_master #(
  parameter int unsigned DIV = 250
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [36:0] i2ccmd,
  input  logic        i2cstart,
  output logic        i2cbusy,
  output logic        done,
  output logic        ack_err,
  output logic [23:0] rdata,
  output logic        scl_oe,
  output logic        sda_oe,
  input  logic        scl_i,
  input  logic        sda_i
);

  typedef enum logic [2:0] {S_IDLE, S_START, S_BIT, S_ACK, S_STOP, S_FREE} state_t;

  localparam logic [15:0] DIV_M1 = 16'(DIV - 1);

  state_t      state;
  logic [15:0] cnt;
  logic [1:0]  qtr;
  logic [2:0]  bit_idx;
  logic [1:0]  byte_idx;
  logic [3:0]  cmd_n;
  logic        cmd_rw;
  logic [23:0] payload;
  logic [7:0]  shreg;
  logic [7:0]  next_byte;
  logic        stall, tick, accept, read_byte, last_byte;

  assign accept    = i2cstart && !i2cbusy && i2ccmd[36] &&
                     (i2ccmd[35:32] != 4'd0) && (i2ccmd[35:32] <= 4'd4);
  // SCL released by us but still low means a slave is stretching the clock.
  assign stall     = !scl_oe && !scl_i;
  assign tick      = i2cbusy && !stall && (cnt == DIV_M1);
  assign read_byte = cmd_rw && (byte_idx != 2'd0);
  assign last_byte = ({2'b00, byte_idx} == (cmd_n - 4'd1));

  always_comb begin
    next_byte = payload[7:0];
    case (byte_idx)
      2'd0:    next_byte = payload[23:16];
      2'd1:    next_byte = payload[15:8];
      default: next_byte = payload[7:0];
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst || !i2cbusy) begin
      cnt <= '0;
    end else if (!stall) begin
      cnt <= (cnt == DIV_M1) ? '0 : cnt + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      i2cbusy  <= 1'b0;
      done     <= 1'b0;
      ack_err  <= 1'b0;
      rdata    <= '0;
      scl_oe   <= 1'b0;
      sda_oe   <= 1'b0;
      qtr      <= '0;
      bit_idx  <= '0;
      byte_idx <= '0;
      cmd_n    <= '0;
      cmd_rw   <= 1'b0;
      payload  <= '0;
      shreg    <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (accept) begin
            state    <= S_START;
            i2cbusy  <= 1'b1;
            ack_err  <= 1'b0;
            rdata    <= '0;
            cmd_n    <= i2ccmd[35:32];
            cmd_rw   <= i2ccmd[24];
            payload  <= i2ccmd[23:0];
            shreg    <= i2ccmd[31:24];
            qtr      <= '0;
            bit_idx  <= '0;
            byte_idx <= '0;
            sda_oe   <= 1'b1;
          end
        end
        S_START: begin
          if (tick) begin
            if (qtr == 2'd1) begin
              state  <= S_BIT;
              qtr    <= '0;
              scl_oe <= 1'b1;
              sda_oe <= !shreg[7];
            end else begin
              qtr <= qtr + 2'd1;
            end
          end
        end
        S_BIT: begin
          if (tick) begin
            qtr <= qtr + 2'd1;
            case (qtr)
              2'd1: scl_oe <= 1'b0;
              // One shift register both sends (MSB out) and receives (LSB in).
              2'd2: shreg <= {shreg[6:0], sda_i};
              2'd3: begin
                scl_oe <= 1'b1;
                if (bit_idx == 3'd7) begin
                  state   <= S_ACK;
                  bit_idx <= '0;
                  if (read_byte) begin
                    rdata  <= {rdata[15:0], shreg};
                    sda_oe <= !last_byte;
                  end else begin
                    sda_oe <= 1'b0;
                  end
                end else begin
                  bit_idx <= bit_idx + 3'd1;
                  sda_oe  <= !read_byte && !shreg[7];
                end
              end
              default: ;
            endcase
          end
        end
        S_ACK: begin
          if (tick) begin
            qtr <= qtr + 2'd1;
            case (qtr)
              2'd1: scl_oe <= 1'b0;
              2'd2: if (!read_byte && sda_i) ack_err <= 1'b1;
              2'd3: begin
                scl_oe <= 1'b1;
                if (ack_err || last_byte) begin
                  state  <= S_STOP;
                  sda_oe <= 1'b1;
                end else begin
                  state    <= S_BIT;
                  byte_idx <= byte_idx + 2'd1;
                  shreg    <= next_byte;
                  sda_oe   <= !cmd_rw && !next_byte[7];
                end
              end
              default: ;
            endcase
          end
        end
        S_STOP: begin
          if (tick) begin
            qtr <= qtr + 2'd1;
            case (qtr)
              2'd1: scl_oe <= 1'b0;
              2'd2: sda_oe <= 1'b0;
              2'd3: state  <= S_FREE;
              default: ;
            endcase
          end
        end
        S_FREE: begin
          if (tick) begin
            qtr <= qtr + 2'd1;
            if (qtr == 2'd3) begin
              state   <= S_IDLE;
              i2cbusy <= 1'b0;
              done    <= 1'b1;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_cmd_master.sv
// Bench for i2c_cmd_master: open-drain bus with a byte-level slave model that
// ACKs/NACKs, returns read data, stretches SCL on request and logs bus bytes.
module tb_i2c_cmd_master;

  localparam int DIV = 4;
  localparam logic [36:0] CMD_WR = {1'b1, 4'h3, 7'h5d, 1'b0, 8'h07, 8'hA5, 8'h00};

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [36:0] i2ccmd = '0;
  logic        i2cstart = 1'b0;
  logic        i2cbusy, done, ack_err, scl_oe, sda_oe, scl_i, sda_i;
  logic [23:0] rdata;
  logic        stretch = 1'b0;
  logic        slave_sda = 1'b0;

  assign scl_i = !(scl_oe || stretch);
  assign sda_i = !(sda_oe || slave_sda);

  i2c_cmd_master #(.DIV(DIV)) dut (
    .clk(clk), .rst(rst), .i2ccmd(i2ccmd), .i2cstart(i2cstart),
    .i2cbusy(i2cbusy), .done(done), .ack_err(ack_err), .rdata(rdata),
    .scl_oe(scl_oe), .sda_oe(sda_oe), .scl_i(scl_i), .sda_i(sda_i)
  );

  int checks = 0;
  int errors = 0;

  logic [7:0] exp_q[$];
  logic [7:0] bus_q[$];
  logic       ack_q[$];
  logic [7:0] rd_data [3];
  logic       nack_addr = 1'b0;
  logic       stretch_arm = 1'b0;
  logic       mon_clr = 1'b0;
  int         n_start = 0, n_stop = 0, n_done = 0, busy_cyc = 0;
  int         rel_cnt = 0, stretch_left = 0, bitc = 0, bidx = 0;
  logic       rw = 1'b0, drv = 1'b0, last_ack = 1'b0;
  logic       prev_scl = 1'b1, prev_sda = 1'b1, prev_scl_oe = 1'b0;
  logic       scl_now, sda_now;
  logic [7:0] sh = '0, cur_rd = '0;

  // Clock / reset
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Bus monitor and slave model, evaluated away from the active edge.
  initial begin : monitor
    forever begin
      @(negedge clk);
      if (mon_clr) begin
        bus_q.delete(); ack_q.delete();
        n_start = 0; n_stop = 0; n_done = 0; busy_cyc = 0; rel_cnt = 0;
        bitc = 0; bidx = 0; rw = 1'b0; drv = 1'b0; slave_sda = 1'b0;
        stretch = 1'b0; stretch_left = 0;
      end else begin
        if (i2cbusy) busy_cyc++;
        if (done) n_done++;
        if (stretch) begin
          if (stretch_left == 0) stretch = 1'b0;
          else stretch_left--;
        end
        if (prev_scl_oe && !scl_oe) begin
          rel_cnt++;
          if (stretch_arm && rel_cnt == 4) begin
            stretch = 1'b1;
            stretch_left = 36;
          end
        end
      end
      scl_now = !(scl_oe || stretch);
      sda_now = !(sda_oe || slave_sda);
      if (!mon_clr) begin
        if (prev_scl && scl_now && prev_sda && !sda_now) begin
          n_start++; bitc = 0; bidx = 0; drv = 1'b0; slave_sda = 1'b0;
        end else if (prev_scl && scl_now && !prev_sda && sda_now) begin
          n_stop++;
        end else if (!prev_scl && scl_now) begin
          if (bitc < 8) sh = {sh[6:0], sda_now};
          else begin
            ack_q.push_back(sda_now);
            last_ack = sda_now;
          end
          bitc++;
        end else if (prev_scl && !scl_now) begin
          if (bitc == 8) begin
            bus_q.push_back(sh);
            if (bidx == 0) rw = sh[0];
            drv = 1'b0;
            slave_sda = (bidx == 0) ? !nack_addr : !rw;
          end else if (bitc == 9) begin
            bitc = 0;
            bidx++;
            if (rw && !last_ack && bidx <= 3) begin
              cur_rd = rd_data[bidx-1];
              drv = 1'b1;
              slave_sda = !cur_rd[7];
            end else begin
              drv = 1'b0;
              slave_sda = 1'b0;
            end
          end else if (drv) begin
            slave_sda = !cur_rd[7-bitc];
          end else begin
            slave_sda = 1'b0;
          end
        end
      end
      prev_scl = scl_now;
      prev_sda = sda_now;
      prev_scl_oe = scl_oe;
    end
  end

  // Driver tasks
  task automatic mon_reset();
    @(posedge clk); mon_clr = 1'b1;
    @(posedge clk); mon_clr = 1'b0;
  endtask

  task automatic send_cmd(input logic [36:0] c);
    @(negedge clk);
    i2ccmd = c;
    i2cstart = 1'b1;
    @(negedge clk);
    i2cstart = 1'b0;
  endtask

  task automatic wait_done(input int budget, output bit got);
    got = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (done) begin
        got = 1'b1;
        break;
      end
    end
    repeat (3) @(negedge clk);
  endtask

  // Scenarios
  task automatic test_reset();
    checks++; if (i2cbusy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", i2cbusy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", done); end
    checks++; if (ack_err !== 1'b0) begin errors++; $display("FAIL reset_ack_err: got %b expected 0", ack_err); end
    checks++; if (rdata !== 24'h0) begin errors++; $display("FAIL reset_rdata: got %h expected 000000", rdata); end
    checks++; if (scl_oe !== 1'b0) begin errors++; $display("FAIL reset_scl_oe: got %b expected 0", scl_oe); end
    checks++; if (sda_oe !== 1'b0) begin errors++; $display("FAIL reset_sda_oe: got %b expected 0", sda_oe); end
  endtask

  task automatic test_write();
    bit got;
    logic [7:0] a;
    logic [2:0] exp_ack = 3'b000;
    mon_reset();
    send_cmd(CMD_WR);
    wait_done(2000, got);
    checks++; if (got !== 1'b1) begin errors++; $display("FAIL write_done: got %0d expected 1", got); end
    exp_q = '{8'hBA, 8'h07, 8'hA5};
    checks++; if (bus_q.size() != 3) begin errors++; $display("FAIL write_nbytes: got %0d expected 3", bus_q.size()); end
    while (exp_q.size() > 0) begin
      a = (bus_q.size() > 0) ? bus_q.pop_front() : 8'hxx;
      checks++; if (a !== exp_q[0]) begin errors++; $display("FAIL write_byte: got %h expected %h", a, exp_q[0]); end
      void'(exp_q.pop_front());
    end
    for (int i = 0; i < 3; i++) begin
      checks++; if (ack_q.size() != 3 || ack_q[i] !== exp_ack[2-i]) begin errors++; $display("FAIL write_ack%0d: got %b expected %b", i, (ack_q.size() > i) ? ack_q[i] : 1'bx, exp_ack[2-i]); end
    end
    checks++; if (n_start != 1 || n_stop != 1) begin errors++; $display("FAIL write_start_stop: got %0d/%0d expected 1/1", n_start, n_stop); end
    checks++; if (busy_cyc < 470 || busy_cyc > 474) begin errors++; $display("FAIL write_busy_len: got %0d expected 472", busy_cyc); end
    checks++; if (n_done != 1) begin errors++; $display("FAIL write_done_count: got %0d expected 1", n_done); end
    checks++; if (ack_err !== 1'b0) begin errors++; $display("FAIL write_ack_err: got %b expected 0", ack_err); end
  endtask

  task automatic test_nack();
    bit got;
    mon_reset();
    nack_addr = 1'b1;
    send_cmd({1'b1, 4'h2, 7'h74, 1'b0, 8'h01, 16'h0});
    wait_done(2000, got);
    nack_addr = 1'b0;
    checks++; if (got !== 1'b1) begin errors++; $display("FAIL nack_done: got %0d expected 1", got); end
    checks++; if (bus_q.size() != 1 || bus_q[0] !== 8'hE8) begin errors++; $display("FAIL nack_bytes: got %0d bytes first %h expected 1 byte E8", bus_q.size(), (bus_q.size() > 0) ? bus_q[0] : 8'hxx); end
    checks++; if (ack_q.size() != 1 || ack_q[0] !== 1'b1) begin errors++; $display("FAIL nack_ack_slots: got %0d slots expected 1 NACK", ack_q.size()); end
    checks++; if (ack_err !== 1'b1) begin errors++; $display("FAIL nack_ack_err: got %b expected 1", ack_err); end
    checks++; if (busy_cyc < 182 || busy_cyc > 186) begin errors++; $display("FAIL nack_busy_len: got %0d expected 184", busy_cyc); end
    checks++; if (n_start != 1 || n_stop != 1) begin errors++; $display("FAIL nack_start_stop: got %0d/%0d expected 1/1", n_start, n_stop); end
  endtask

  task automatic test_read();
    bit got;
    logic [7:0] a;
    logic [3:0] exp_ack = 4'b0001;
    mon_reset();
    rd_data = '{8'h12, 8'h34, 8'h56};
    send_cmd({1'b1, 4'h4, 7'h5d, 1'b1, 24'h0});
    wait_done(3000, got);
    checks++; if (got !== 1'b1) begin errors++; $display("FAIL read_done: got %0d expected 1", got); end
    checks++; if (rdata !== 24'h123456) begin errors++; $display("FAIL read_rdata: got %h expected 123456", rdata); end
    exp_q = '{8'hBB, 8'h12, 8'h34, 8'h56};
    checks++; if (bus_q.size() != 4) begin errors++; $display("FAIL read_nbytes: got %0d expected 4", bus_q.size()); end
    while (exp_q.size() > 0) begin
      a = (bus_q.size() > 0) ? bus_q.pop_front() : 8'hxx;
      checks++; if (a !== exp_q[0]) begin errors++; $display("FAIL read_byte: got %h expected %h", a, exp_q[0]); end
      void'(exp_q.pop_front());
    end
    for (int i = 0; i < 4; i++) begin
      checks++; if (ack_q.size() != 4 || ack_q[i] !== exp_ack[3-i]) begin errors++; $display("FAIL read_ack%0d: got %b expected %b", i, (ack_q.size() > i) ? ack_q[i] : 1'bx, exp_ack[3-i]); end
    end
    checks++; if (ack_err !== 1'b0) begin errors++; $display("FAIL read_ack_err: got %b expected 0", ack_err); end
    checks++; if (busy_cyc < 614 || busy_cyc > 618) begin errors++; $display("FAIL read_busy_len: got %0d expected 616", busy_cyc); end
  endtask

  task automatic test_ignore();
    bit got;
    logic [7:0] a;
    mon_reset();
    send_cmd(CMD_WR);
    repeat (20) @(negedge clk);
    send_cmd({1'b1, 4'h2, 7'h11, 1'b0, 24'hFF0000});
    wait_done(2000, got);
    checks++; if (got !== 1'b1) begin errors++; $display("FAIL ignore_busy_done: got %0d expected 1", got); end
    checks++; if (n_done != 1 || n_start != 1) begin errors++; $display("FAIL ignore_busy_counts: got done %0d start %0d expected 1 1", n_done, n_start); end
    checks++; if (busy_cyc < 470 || busy_cyc > 474) begin errors++; $display("FAIL ignore_busy_len: got %0d expected 472", busy_cyc); end
    exp_q = '{8'hBA, 8'h07, 8'hA5};
    checks++; if (bus_q.size() != 3) begin errors++; $display("FAIL ignore_nbytes: got %0d expected 3", bus_q.size()); end
    while (exp_q.size() > 0) begin
      a = (bus_q.size() > 0) ? bus_q.pop_front() : 8'hxx;
      checks++; if (a !== exp_q[0]) begin errors++; $display("FAIL ignore_byte: got %h expected %h", a, exp_q[0]); end
      void'(exp_q.pop_front());
    end
    mon_reset();
    send_cmd({1'b0, 4'h3, 7'h5d, 1'b0, 24'h07A500});
    send_cmd({1'b1, 4'h5, 7'h5d, 1'b0, 24'h07A500});
    send_cmd({1'b1, 4'h0, 7'h5d, 1'b0, 24'h07A500});
    repeat (40) @(negedge clk);
    checks++; if (busy_cyc != 0) begin errors++; $display("FAIL ignore_idle_busy: got %0d expected 0", busy_cyc); end
    checks++; if (n_done != 0) begin errors++; $display("FAIL ignore_idle_done: got %0d expected 0", n_done); end
    checks++; if (n_start != 0 || scl_oe !== 1'b0 || sda_oe !== 1'b0) begin errors++; $display("FAIL ignore_idle_bus: got start %0d scl %b sda %b expected 0 0 0", n_start, scl_oe, sda_oe); end
  endtask

  task automatic test_stretch();
    bit got;
    logic [7:0] a;
    mon_reset();
    stretch_arm = 1'b1;
    send_cmd(CMD_WR);
    wait_done(2000, got);
    stretch_arm = 1'b0;
    checks++; if (got !== 1'b1) begin errors++; $display("FAIL stretch_done: got %0d expected 1", got); end
    checks++; if (busy_cyc < 507 || busy_cyc > 511) begin errors++; $display("FAIL stretch_busy_len: got %0d expected 509", busy_cyc); end
    exp_q = '{8'hBA, 8'h07, 8'hA5};
    checks++; if (bus_q.size() != 3) begin errors++; $display("FAIL stretch_nbytes: got %0d expected 3", bus_q.size()); end
    while (exp_q.size() > 0) begin
      a = (bus_q.size() > 0) ? bus_q.pop_front() : 8'hxx;
      checks++; if (a !== exp_q[0]) begin errors++; $display("FAIL stretch_byte: got %h expected %h", a, exp_q[0]); end
      void'(exp_q.pop_front());
    end
    checks++; if (ack_err !== 1'b0 || n_stop != 1) begin errors++; $display("FAIL stretch_status: got ack_err %b stops %0d expected 0 1", ack_err, n_stop); end
  endtask

  task automatic test_reset_mid();
    bit got;
    logic [7:0] a;
    mon_reset();
    send_cmd(CMD_WR);
    repeat (26) @(negedge clk);
    checks++; if (scl_oe !== 1'b1 || i2cbusy !== 1'b1) begin errors++; $display("FAIL midrst_pre: got scl %b busy %b expected 1 1", scl_oe, i2cbusy); end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++; if (scl_oe !== 1'b0) begin errors++; $display("FAIL midrst_scl: got %b expected 0", scl_oe); end
    checks++; if (sda_oe !== 1'b0) begin errors++; $display("FAIL midrst_sda: got %b expected 0", sda_oe); end
    checks++; if (i2cbusy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL midrst_busy: got busy %b done %b expected 0 0", i2cbusy, done); end
    repeat (5) @(negedge clk);
    mon_reset();
    send_cmd(CMD_WR);
    wait_done(2000, got);
    checks++; if (got !== 1'b1) begin errors++; $display("FAIL midrst_after_done: got %0d expected 1", got); end
    exp_q = '{8'hBA, 8'h07, 8'hA5};
    checks++; if (bus_q.size() != 3) begin errors++; $display("FAIL midrst_nbytes: got %0d expected 3", bus_q.size()); end
    while (exp_q.size() > 0) begin
      a = (bus_q.size() > 0) ? bus_q.pop_front() : 8'hxx;
      checks++; if (a !== exp_q[0]) begin errors++; $display("FAIL midrst_byte: got %h expected %h", a, exp_q[0]); end
      void'(exp_q.pop_front());
    end
    checks++; if (ack_err !== 1'b0 || busy_cyc < 470 || busy_cyc > 474) begin errors++; $display("FAIL midrst_status: got ack_err %b busy %0d expected 0 472", ack_err, busy_cyc); end
  endtask

  initial begin
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    test_reset();
    test_write();
    test_nack();
    test_read();
    test_ignore();
    test_stretch();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
